lab3_selftest: RTL and testbench

On-chip stimulus and checker for the lab3 button-to-LED logic. It is the driving and checking side of the BUTTONS/LEDS interface. On START it sweeps all 16 BUTTONS patterns into lab3 and waits a settle interval for each. It then compares the LEDS it samples back against the reference equations and reports error count, first failing pattern and pass/fail.

---
 rtl/lab3_selftest.sv | 107 ++++++++++
 tb/tb_lab3_selftest.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/lab3_selftest.sv
// Self-test driver/checker for the lab3 button-to-LED logic: sweeps all 16
// BUTTONS patterns, compares LEDS against the reference equations, reports results.
module lab3_selftest #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  output logic [3:0] BUTTONS_OUT,
  input  logic [5:0] LEDS_IN,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [4:0] ERR_COUNT,
  output logic [3:0] FIRST_FAIL,
  output logic       MISMATCH
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, FINISH} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_nxt;
  logic [3:0]       pattern, pattern_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [4:0]       err, err_nxt;
  logic [3:0]       first_fail, first_fail_nxt;
  logic             mismatch_nxt;
  logic             exp_1, exp_3;
  logic [5:0]       expected;
  logic             led_fail;

  assign exp_1    = pattern[1] & ~pattern[2];
  assign exp_3    = pattern[2] & pattern[3];
  assign expected = {2'b00, exp_3, exp_1 | exp_3, exp_1, ~pattern[0]};
  assign led_fail = (LEDS_IN != expected);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      pattern    <= '0;
      cnt        <= '0;
      err        <= '0;
      first_fail <= '0;
      MISMATCH   <= 1'b0;
    end else begin
      state      <= state_nxt;
      pattern    <= pattern_nxt;
      cnt        <= cnt_nxt;
      err        <= err_nxt;
      first_fail <= first_fail_nxt;
      MISMATCH   <= mismatch_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pattern_nxt    = pattern;
    cnt_nxt        = cnt;
    err_nxt        = err;
    first_fail_nxt = first_fail;
    mismatch_nxt   = 1'b0;
    case (state)
      IDLE, FINISH: begin
        if (START) begin
          state_nxt      = SETTLE;
          pattern_nxt    = '0;
          cnt_nxt        = '0;
          err_nxt        = '0;
          first_fail_nxt = '0;
        end
      end
      SETTLE: begin
        if (cnt == CNT_LAST) begin
          state_nxt = CHECK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      CHECK: begin
        // The compare result is registered, so MISMATCH lands in the cycle after CHECK.
        if (led_fail) begin
          err_nxt      = err + 5'd1;
          mismatch_nxt = 1'b1;
          if (err == '0) first_fail_nxt = pattern;
        end
        if (pattern == 4'd15) begin
          state_nxt = FINISH;
        end else begin
          pattern_nxt = pattern + 4'd1;
          state_nxt   = SETTLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign BUSY        = (state == SETTLE) || (state == CHECK);
  assign DONE        = (state == FINISH);
  assign PASS        = DONE && (err == '0);
  assign ERR_COUNT   = err;
  assign FIRST_FAIL  = first_fail;
  assign BUTTONS_OUT = BUSY ? pattern : '0;

endmodule

// File: tb/tb_lab3_selftest.sv
// Scoreboard bench for lab3_selftest: a lab3 model with injectable per-pattern
// LED faults feeds the DUT; expected results come from the fault table.
module tb_lab3_selftest;

  logic       CLK = 1'b0;
  logic       RESET, START, START1;
  logic [3:0] buttons, buttons1;
  logic [5:0] leds, leds1;
  logic       busy, done, pass, mm;
  logic       busy1, done1, pass1, mm1;
  logic [4:0] err, err1;
  logic [3:0] ff, ff1;

  logic [5:0] fault_mask [16];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int err;
    int first;
    int pass;
  } result_t;

  result_t res_q[$];
  int      mm_q[$];

  always #5 CLK = ~CLK;

  lab3_selftest #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
    .CLK(CLK), .RESET(RESET), .START(START), .BUTTONS_OUT(buttons), .LEDS_IN(leds),
    .BUSY(busy), .DONE(done), .PASS(pass), .ERR_COUNT(err), .FIRST_FAIL(ff), .MISMATCH(mm)
  );

  lab3_selftest #(.SETTLE_CYCLES(1), .CNT_W(8)) dut1 (
    .CLK(CLK), .RESET(RESET), .START(START1), .BUTTONS_OUT(buttons1), .LEDS_IN(leds1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .ERR_COUNT(err1), .FIRST_FAIL(ff1), .MISMATCH(mm1)
  );

  function automatic logic [5:0] lab3_ideal(input logic [3:0] b);
    logic e1, e3;
    e1 = b[1] & ~b[2];
    e3 = b[2] & b[3];
    return {2'b00, e3, e1 | e3, e1, ~b[0]};
  endfunction

  always_comb leds  = lab3_ideal(buttons) ^ fault_mask[buttons];
  always_comb leds1 = lab3_ideal(buttons1);

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Expected outcome follows directly from which patterns have a corrupted response.
  task automatic push_expected();
    result_t r;
    r.err = 0;
    r.first = 0;
    for (int p = 0; p < 16; p++) begin
      if (fault_mask[p] != '0) begin
        if (r.err == 0) r.first = p;
        r.err++;
        mm_q.push_back(p);
      end
    end
    r.pass = (r.err == 0) ? 1 : 0;
    res_q.push_back(r);
  endtask

  task automatic run_sweep(input int extra_start);
    int n;
    push_expected();
    @(negedge CLK) START = 1'b1;
    @(negedge CLK) START = 1'b0;
    check("start_busy", busy, 1);
    check("start_done_clear", done, 0);
    check("start_err_clear", err, 0);
    check("start_ff_clear", ff, 0);
    check("start_pass_clear", pass, 0);
    n = 0;
    while (!done && n < 300) begin
      @(negedge CLK);
      n++;
      START = (extra_start > 0 && n == extra_start) ? 1'b1 : 1'b0;
      if (!done) check("busy_during_sweep", busy, 1);
    end
    START = 1'b0;
    check("done_latency", n, 80);
    check("finish_busy", busy, 0);
    check("finish_buttons", buttons, 0);
  endtask

  task automatic clear_faults();
    for (int p = 0; p < 16; p++) fault_mask[p] = '0;
  endtask

  // Monitor: pops expected results whenever the DUT presents MISMATCH or DONE.
  initial begin
    logic       done_q;
    logic [3:0] prev_buttons;
    result_t    r;
    int         exp_p;
    done_q = 1'b0;
    prev_buttons = '0;
    forever begin
      @(negedge CLK);
      if (!RESET) begin
        if (mm) begin
          checks++;
          if (mm_q.size() == 0) begin
            errors++;
            $display("FAIL mismatch_unexpected actual_pattern=%0d required=none", prev_buttons);
          end else begin
            exp_p = mm_q.pop_front();
            if (int'(prev_buttons) != exp_p) begin
              errors++;
              $display("FAIL mismatch_pattern actual=%0d expected=%0d", prev_buttons, exp_p);
            end
          end
        end
        if (done && !done_q) begin
          checks++;
          if (res_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected actual=1 expected=0");
          end else begin
            r = res_q.pop_front();
            check("err_count", err, r.err);
            check("first_fail", ff, r.first);
            check("pass", pass, r.pass);
            check("mismatch_pulses_left", mm_q.size(), 0);
          end
        end
      end
      done_q = done;
      prev_buttons = buttons;
    end
  end

  initial begin
    RESET = 1'b1;
    START = 1'b0;
    START1 = 1'b0;
    clear_faults();
    #1;
    check("rst_buttons", buttons, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_err", err, 0);
    check("rst_ff", ff, 0);
    check("rst_mm", mm, 0);
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    repeat (2) @(negedge CLK);
    check("idle_busy", busy, 0);

    // correct model
    run_sweep(0);

    // LEDS[3] stuck at 0
    for (int p = 0; p < 16; p++) begin
      logic [5:0] ideal;
      ideal = lab3_ideal(4'(p));
      fault_mask[p] = ideal[3] ? 6'b001000 : 6'b000000;
    end
    run_sweep(0);

    // LEDS[5] high only for pattern 6, plus an ignored START mid-sweep
    clear_faults();
    fault_mask[6] = 6'b100000;
    run_sweep(20);

    // restarts from FINISH with randomized fault tables
    for (int s = 0; s < 5; s++) begin
      for (int p = 0; p < 16; p++)
        fault_mask[p] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'b000000;
      run_sweep(0);
    end

    // reset in the middle of a sweep
    clear_faults();
    @(negedge CLK) START = 1'b1;
    @(negedge CLK) START = 1'b0;
    repeat (30) @(negedge CLK);
    #2 RESET = 1'b1;
    #1;
    check("midrst_buttons", buttons, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_pass", pass, 0);
    check("midrst_err", err, 0);
    check("midrst_ff", ff, 0);
    @(negedge CLK) RESET = 1'b0;
    run_sweep(0);

    // SETTLE_CYCLES=1 instance: each pattern held two cycles
    @(negedge CLK) START1 = 1'b1;
    @(negedge CLK) START1 = 1'b0;
    for (int n = 0; n < 32; n++) begin
      check("s1_buttons", buttons1, n / 2);
      check("s1_not_done", done1, 0);
      check("s1_no_mismatch", mm1, 0);
      @(negedge CLK);
    end
    check("s1_done", done1, 1);
    check("s1_buttons_zero", buttons1, 0);
    check("s1_pass", pass1, 1);
    check("s1_err", err1, 0);
    check("s1_ff", ff1, 0);
    check("s1_busy", busy1, 0);

    repeat (2) @(negedge CLK);
    check("results_left", res_q.size(), 0);
    check("mismatches_left", mm_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
